dport_enc8b10b: RTL

Two-symbol-per-cycle 8b/10b encoder for the DisplayPort main link. It sits directly downstream of the scrambler and consumes its 16-bit data / 2-bit K-flag stream. It produces 20-bit transmission words for the serializer and tracks running disparity (RD) across both symbols of each cycle. Byte 0 (`indata[7:0]`) is transmitted before byte 1.

---
 rtl/dport_enc8b10b_if.sv | 12 +
 rtl/dport_enc8b10b.sv | 109 ++++++++++
 2 files changed

// File: rtl/dport_enc8b10b_if.sv
// Symbol bus between the scrambler, the 8b/10b encoder and the serializer.
// The encoder uses the slave modport.
interface dport_enc8b10b_if;
    logic [15:0] indata;
    logic [1:0]  inisk;
    logic [19:0] outdata;
    logic [1:0]  outerr;
    logic        outrd;

    modport master (output indata, output inisk, input outdata, input outerr, input outrd);
    modport slave  (input indata, input inisk, output outdata, output outerr, output outrd);
endinterface

// File: rtl/dport_enc8b10b.sv
// Two-symbol 8b/10b encoder with a running-disparity chain. Latency is one cycle.
// There is no backpressure: one word is accepted every cycle.
module dport_enc8b10b (
    input  logic            clk,
    input  logic            reset,
    dport_enc8b10b_if.slave bus
);
    typedef struct packed {
        logic [9:0] code;
        logic       err;
        logic       rd;
    } sym_t;

    // 5b/6b codes, RD- column, written as abcdei with a in the MSB
    function automatic logic [5:0] f_tab6(input logic [4:0] x);
        case (x)
            5'd0:  f_tab6 = 6'b100111;  5'd1:  f_tab6 = 6'b011101;
            5'd2:  f_tab6 = 6'b101101;  5'd3:  f_tab6 = 6'b110001;
            5'd4:  f_tab6 = 6'b110101;  5'd5:  f_tab6 = 6'b101001;
            5'd6:  f_tab6 = 6'b011001;  5'd7:  f_tab6 = 6'b111000;
            5'd8:  f_tab6 = 6'b111001;  5'd9:  f_tab6 = 6'b100101;
            5'd10: f_tab6 = 6'b010101;  5'd11: f_tab6 = 6'b110100;
            5'd12: f_tab6 = 6'b001101;  5'd13: f_tab6 = 6'b101100;
            5'd14: f_tab6 = 6'b011100;  5'd15: f_tab6 = 6'b010111;
            5'd16: f_tab6 = 6'b011011;  5'd17: f_tab6 = 6'b100011;
            5'd18: f_tab6 = 6'b010011;  5'd19: f_tab6 = 6'b110010;
            5'd20: f_tab6 = 6'b001011;  5'd21: f_tab6 = 6'b101010;
            5'd22: f_tab6 = 6'b011010;  5'd23: f_tab6 = 6'b111010;
            5'd24: f_tab6 = 6'b110011;  5'd25: f_tab6 = 6'b100110;
            5'd26: f_tab6 = 6'b010110;  5'd27: f_tab6 = 6'b110110;
            5'd28: f_tab6 = 6'b001110;  5'd29: f_tab6 = 6'b101110;
            5'd30: f_tab6 = 6'b011110;  default: f_tab6 = 6'b101011;
        endcase
    endfunction

    // 3b/4b codes, RD- column, fghj with f in the MSB; kcol selects the K/A7 column
    function automatic logic [3:0] f_tab4(input logic [2:0] y, input logic kcol);
        case (y)
            3'd0:    f_tab4 = 4'b1011;
            3'd1:    f_tab4 = kcol ? 4'b0110 : 4'b1001;
            3'd2:    f_tab4 = kcol ? 4'b1010 : 4'b0101;
            3'd3:    f_tab4 = 4'b1100;
            3'd4:    f_tab4 = 4'b1101;
            3'd5:    f_tab4 = kcol ? 4'b0101 : 4'b1010;
            3'd6:    f_tab4 = kcol ? 4'b1001 : 4'b0110;
            default: f_tab4 = kcol ? 4'b0111 : 4'b1110;
        endcase
    endfunction

    function automatic sym_t f_enc(input logic [7:0] b, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       legal, k28, a7, use_k4, unb6, unb4, rd6;
        logic [5:0] c6;
        logic [3:0] c4;
        logic [9:0] msb;
        sym_t       s;
        x      = b[4:0];
        y      = b[7:5];
        legal  = k & ((x == 5'd28) |
                      ((y == 3'd7) & ((x == 5'd23) | (x == 5'd27) | (x == 5'd29) | (x == 5'd30))));
        k28    = legal & (x == 5'd28);
        c6     = k28 ? 6'b001111 : f_tab6(x);
        unb6   = ($countones(c6) != 3);
        // D.7 is neutral but still swaps to 000111 at RD+
        if (rd & (k28 | unb6 | (x == 5'd7)))
            c6 = ~c6;
        rd6    = rd ^ unb6;
        a7     = (y == 3'd7) & ((~rd6 & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20))) |
                                ( rd6 & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14))));
        use_k4 = legal | a7;
        c4     = f_tab4(y, use_k4);
        unb4   = ($countones(c4) != 2);
        if (rd6 & (use_k4 | unb4 | (y == 3'd3) | (y == 3'd7)))
            c4 = ~c4;
        msb    = {c6, c4};
        s.code = '0;
        for (int i = 0; i < 10; i++)
            s.code[i] = msb[9-i];
        s.err  = k & ~legal;
        s.rd   = rd6 ^ unb4;
        return s;
    endfunction

    logic [19:0] r_outdata;
    logic [1:0]  r_outerr;
    logic        r_rd;
    sym_t        w_s0;
    sym_t        w_s1;

    assign w_s0 = f_enc(bus.indata[7:0],  bus.inisk[0], r_rd);
    assign w_s1 = f_enc(bus.indata[15:8], bus.inisk[1], w_s0.rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outdata <= '0;
            r_outerr  <= '0;
            r_rd      <= 1'b0;
        end else begin
            r_outdata <= {w_s1.code, w_s0.code};
            r_outerr  <= {w_s1.err, w_s0.err};
            r_rd      <= w_s1.rd;
        end
    end

    assign bus.outdata = r_outdata;
    assign bus.outerr  = r_outerr;
    assign bus.outrd   = r_rd;
endmodule
